log_lut_ctrl: RTL and testbench
===============================

Name: log_lut_ctrl

Overview:
- Sequencer/configurator for the log_block datapath of the AWGN core.
- Loads the 128x52 log-coefficient LUT (c0/c1 table) from a host word stream after reset or on request.
- Gates uniform samples into log_block only when the LUT is valid, and tracks the fixed datapath latency to emit a qualified e_valid.
- Drains in-flight samples before any reload so that no output is computed from a half-written table.

Parameters:
- DEPTH, 128, LUT entries; the address counter runs 0..DEPTH-1.
- ADDR_W, 7, LUT address width.
- DATA_W, 52, LUT word width ({c0[29:0], c1[21:0]}).
- U_W, 48, uniform sample width.
- E_W, 31, log output width.
- LAT, 2, log_block register stages from u0 to e.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  request a LUT (re)load; single-cycle pulse.
- cfg_valid  in  1  cfg_data holds a LUT word.
- cfg_ready  out  1  controller accepts a cfg word this cycle.
- cfg_data  in  DATA_W  LUT word for the current address.
- lut_ok  out  1  LUT fully loaded; datapath usable.
- mem_we  out  1  LUT write enable.
- mem_addr  out  ADDR_W  LUT write address.
- mem_wdata  out  DATA_W  LUT write data.
- addr_sel  out  1  1 = LUT address taken from mem_addr; 0 = from log_block x_e[46:40].
- u_valid  in  1  uniform sample offered.
- u_ready  out  1  sample accepted when u_valid & u_ready.
- u_in  in  U_W  uniform sample.
- log_u0  out  U_W  registered sample driven to log_block u0.
- zero_sub  out  1  pulse: the accepted sample was 0 and was replaced.
- e_in  in  E_W  log_block e output.
- e_valid  out  1  e_out is valid.
- e_out  out  E_W  registered log result.

Behaviour:
- Reset values: state IDLE, all outputs 0 except addr_sel=1. Specifically cfg_ready=0, lut_ok=0, mem_we=0, mem_addr=0, mem_wdata=0, u_ready=0, log_u0=0, zero_sub=0, e_valid=0, e_out=0. The valid shift register vsr[LAT:0] is cleared.
- States:
  - IDLE: addr_sel=1; cfg_start -> LOAD with addr counter = 0.
  - LOAD: cfg_ready=1, addr_sel=1, u_ready=0.
    - Each cfg_valid & cfg_ready cycle registers mem_we=1, mem_addr=cnt, mem_wdata=cfg_data on the next edge, then increments cnt.
    - The write with cnt=DEPTH-1 -> RUN; lut_ok set on that same edge.
    - cfg_valid low: no write; cnt holds.
    - cfg_start while in LOAD is ignored, and the count does not restart.
  - RUN: addr_sel=0, lut_ok=1, u_ready=1.
    - cfg_start -> DRAIN; u_ready drops on that edge, and a sample offered in the same cycle as cfg_start is not accepted.
  - DRAIN: u_ready=0, lut_ok=1, addr_sel=0. When vsr is all zero -> LOAD with cnt=0 and lut_ok cleared on the same edge.
- mem_we is a single-cycle registered strobe; it is 0 in every state other than the cycle after an accepted cfg word.
- Sample path:
  - On an accept edge k, log_u0 <= u_in. If u_in==0, log_u0 <= 1 and zero_sub pulses for one cycle, since the log of 0 is undefined.
  - vsr[0] <= accept; vsr[i] <= vsr[i-1].
  - log_u0 holds its value when there is no accept.
- Output:
  - e_out <= e_in and e_valid <= 1 on the edge where vsr[LAT]=1; otherwise e_valid=0 and e_out holds.
  - Fixed latency: e_valid is high in the cycle following edge k+LAT+1, i.e. 3 edges after accept with LAT=2.
  - There is no output backpressure; one result per accepted sample, in order, full throughput of 1 sample per clock.
- Reset mid-operation (any state): immediately returns to IDLE with all reset values; in-flight vsr bits are discarded and lut_ok=0. A reload requires a new cfg_start.
- Counter width is ADDR_W. DEPTH must equal 2^ADDR_W, so cnt never wraps while in LOAD.

Test Plan:
- Reset release, no cfg_start for 20 cycles, u_valid=1 held -> u_ready=0, e_valid=0, lut_ok=0, addr_sel=1 throughout.
- cfg_start, then 128 words data=i with cfg_valid toggling 1,0 -> exactly 128 mem_we pulses at addresses 0..127 with wdata=address; lut_ok rises on the edge of write 127; state RUN, addr_sel=0.
- In RUN, u_in=48'h800000000000 then 48'h000000000001 back-to-back, with e_in driven by a log_block model -> e_valid high 3 edges after each accept, two consecutive valid cycles, e_out matches the model in order.
- u_in=0 accepted -> log_u0=1, zero_sub single-cycle pulse, and e_valid still appears 3 edges later.
- cfg_start with 3 samples in flight and u_valid held 1 -> u_ready drops immediately, all 3 e_valid still appear, then LOAD begins (cnt=0, lut_ok=0) with no e_valid during LOAD.
- rst asserted after 60 LOAD writes -> all outputs at reset values asynchronously; after release, IDLE persists until cfg_start, and the reload starts at address 0.

Source files
------------

// File: rtl/log_lut_ctrl.sv
// log_lut_ctrl: loads the log-coefficient LUT from a host stream and gates samples through log_block.
module log_lut_ctrl #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 52,
  parameter int U_W    = 48,
  parameter int E_W    = 31,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              lut_ok,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              addr_sel,
  input  logic              u_valid,
  output logic              u_ready,
  input  logic [U_W-1:0]    u_in,
  output logic [U_W-1:0]    log_u0,
  output logic              zero_sub,
  input  logic [E_W-1:0]    e_in,
  output logic              e_valid,
  output logic [E_W-1:0]    e_out
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [LAT:0]      vsr;
  logic              accept;
  // a sample offered alongside a reload request is refused so the drain sees a closed input
  assign accept = u_valid & u_ready & (state == RUN) & ~cfg_start;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cfg_ready <= 1'b0;
      lut_ok    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      addr_sel  <= 1'b1;
      u_ready   <= 1'b0;
      log_u0    <= '0;
      zero_sub  <= 1'b0;
      vsr       <= '0;
      e_valid   <= 1'b0;
      e_out     <= '0;
    end else begin
      mem_we   <= 1'b0;
      zero_sub <= 1'b0;
      vsr      <= {vsr[LAT-1:0], accept};
      e_valid  <= vsr[LAT];
      if (vsr[LAT]) e_out <= e_in;
      if (accept) begin
        log_u0   <= (u_in == '0) ? U_W'(1) : u_in;
        zero_sub <= (u_in == '0);
      end
      case (state)
        IDLE: if (cfg_start) begin
          state     <= LOAD;
          cnt       <= '0;
          cfg_ready <= 1'b1;
          addr_sel  <= 1'b1;
        end
        LOAD: if (cfg_valid && cfg_ready) begin
          mem_we    <= 1'b1;
          mem_addr  <= cnt;
          mem_wdata <= cfg_data;
          cnt       <= cnt + 1'b1;
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state     <= RUN;
            lut_ok    <= 1'b1;
            cfg_ready <= 1'b0;
            addr_sel  <= 1'b0;
            u_ready   <= 1'b1;
          end
        end
        RUN: if (cfg_start) begin
          state   <= DRAIN;
          u_ready <= 1'b0;
        end
        DRAIN: if (vsr == '0) begin
          state     <= LOAD;
          cnt       <= '0;
          lut_ok    <= 1'b0;
          cfg_ready <= 1'b1;
          addr_sel  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_log_lut_ctrl.sv
// tb_log_lut_ctrl: scoreboard bench for log_lut_ctrl with a two-stage log_block model.
module tb_log_lut_ctrl;
  logic        clk = 0, rst = 1, cfg_start = 0, cfg_valid = 0, u_valid = 0;
  logic [51:0] cfg_data = '0;
  logic [47:0] u_in = '0;
  logic [30:0] e_in;
  logic        cfg_ready, lut_ok, mem_we, addr_sel, u_ready, zero_sub, e_valid;
  logic [6:0]  mem_addr;
  logic [51:0] mem_wdata;
  logic [47:0] log_u0;
  logic [30:0] e_out;
  log_lut_ctrl dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .lut_ok(lut_ok), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .addr_sel(addr_sel), .u_valid(u_valid), .u_ready(u_ready),
    .u_in(u_in), .log_u0(log_u0), .zero_sub(zero_sub), .e_in(e_in), .e_valid(e_valid),
    .e_out(e_out)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [30:0] f(input logic [47:0] u);
    return u[47:17] ^ u[30:0];
  endfunction
  // log_block stand-in: u0 -> two register stages -> e
  logic [47:0] p1, p2;
  always @(posedge clk) begin
    p1 <= log_u0;
    p2 <= p1;
  end
  assign e_in = f(p2);
  int cyc = 0, nev = 0, nwr = 0, wexp = 0;
  logic [30:0] exp_q[$];
  int          cyc_q[$];
  always @(posedge clk) begin
    cyc++;
    if (!rst && u_valid && u_ready && !cfg_start) begin
      exp_q.push_back(f(u_in == 48'd0 ? 48'd1 : u_in));
      cyc_q.push_back(cyc);
    end
  end
  always @(negedge clk) if (!rst) begin
    if (e_valid) begin
      nev++;
      chk("ev_in_load", cfg_ready, 0);
      if (exp_q.size() == 0) chk("e_spurious", e_valid, 0);
      else begin
        chk("e_out", e_out, exp_q.pop_front());
        chk("e_latency", cyc - cyc_q.pop_front(), 3);
      end
    end
    if (mem_we) begin
      chk("mem_addr", mem_addr, wexp);
      chk("mem_wdata", mem_wdata, wexp);
      wexp++;
      nwr++;
    end
  end
  task automatic rst_check(input string tag);
    chk({tag, "_flags"}, {cfg_ready, lut_ok, mem_we, u_ready, zero_sub, e_valid, addr_sel}, 7'b0000001);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_u0"}, log_u0, 0);
    chk({tag, "_eout"}, e_out, 0);
  endtask
  task automatic load(input int n, input bit start, input int restart_at);
    int i = 0;
    bit t = 0;
    if (start) begin
      @(negedge clk) cfg_start = 1;
      @(negedge clk) cfg_start = 0;
    end
    for (int k = 0; k < 1000 && i < n; k++) begin
      t = ~t;
      cfg_valid = t;
      cfg_data = 52'(i);
      cfg_start = (k == restart_at);
      if (t && cfg_ready) begin
        i++;
        if (i == n) chk("lut_ok_pre", lut_ok, 0);
      end
      @(negedge clk);
    end
    cfg_valid = 0;
    cfg_start = 0;
    chk("load_count", i, n);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst_check("rst");
    rst = 0;
    u_valid = 1;
    u_in = 48'h5;
    repeat (20) begin
      @(negedge clk);
      chk("idle", {u_ready, e_valid, lut_ok, addr_sel}, 4'b0001);
    end
    u_valid = 0;
    load(128, 1, -1);
    chk("lut_ok", lut_ok, 1);
    chk("run_outs", {addr_sel, u_ready, cfg_ready}, 3'b010);
    @(negedge clk);
    chk("n_writes", nwr, 128);
    chk("we_idle", mem_we, 0);
    u_valid = 1;
    u_in = 48'h800000000000;
    @(negedge clk) u_in = 48'h000000000001;
    @(negedge clk) u_valid = 0;
    repeat (6) @(negedge clk);
    chk("pair_q", exp_q.size(), 0);
    chk("pair_nev", nev, 2);
    u_valid = 1;
    u_in = 48'd0;
    @(negedge clk);
    chk("zero_u0", log_u0, 1);
    chk("zero_sub", zero_sub, 1);
    u_valid = 0;
    @(negedge clk);
    chk("zero_pulse", zero_sub, 0);
    repeat (5) @(negedge clk);
    chk("zero_nev", nev, 3);
    u_valid = 1;
    repeat (3) begin
      u_in = {16'($urandom), $urandom} | 48'd2;
      @(negedge clk);
    end
    cfg_start = 1;
    u_in = 48'h123456789abc;
    @(negedge clk) cfg_start = 0;
    chk("u_ready_drop", u_ready, 0);
    for (int k = 0; k < 20 && !cfg_ready; k++) @(negedge clk);
    chk("drain_to_load", cfg_ready, 1);
    chk("drain_lut_ok", lut_ok, 0);
    chk("drain_nev", nev, 6);
    chk("drain_q", exp_q.size(), 0);
    u_valid = 0;
    wexp = 0;
    load(60, 0, 10);
    chk("partial_lut_ok", lut_ok, 0);
    @(negedge clk);
    chk("partial_writes", wexp, 60);
    #2 rst = 1;
    #1 rst_check("async_rst");
    @(negedge clk) rst = 0;
    wexp = 0;
    nwr = 0;
    repeat (5) begin
      @(negedge clk);
      chk("idle2", {cfg_ready, addr_sel, lut_ok}, 3'b010);
    end
    load(128, 1, -1);
    @(negedge clk);
    chk("reload_writes", nwr, 128);
    chk("reload_lut_ok", lut_ok, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
